frame_stream_reader: RTL and testbench

Parametrised successor to the PSRAM frame downloader. It reads a stored RGB565 frame from PSRAM in fixed bursts and streams it to the display-side pixel queue as 17-bit entries with frame and line markers. It adds integer horizontal and vertical decimation, a configurable source row stride, and a clean abort. It sits between the PSRAM arbiter read port and the LCD output FIFO.

---
 rtl/frame_stream_reader.sv | 263 ++++++++++++++++++++++++++
 tb/tb_frame_stream_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_reader.sv
// Reads a stored RGB565 frame from PSRAM in fixed bursts and streams it, with frame/line
// markers and integer decimation, into the display pixel queue. Optional: FRAME_READER_VFLIP_EN.
module frame_stream_reader #(
  parameter int unsigned MEMORY_BURST = 32,
  parameter int unsigned OUT_WIDTH    = 480,
  parameter int unsigned OUT_HEIGHT   = 272,
  parameter int unsigned SRC_STRIDE   = 640,
  parameter int unsigned X_STEP       = 1,
  parameter int unsigned Y_STEP       = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [20:0] base_addr,
`ifdef FRAME_READER_VFLIP_EN
  input  logic        vflip,
`endif
  input  logic        queue_full,
  output logic [16:0] queue_data_o,
  output logic        wr_en,
  output logic        read_rq,
  input  logic        read_ack,
  output logic [20:0] read_addr,
  output logic        mem_rd_en,
  input  logic [31:0] read_data,
  input  logic        rd_data_valid,
  output logic        busy,
  output logic        download_done
);

  localparam int unsigned AW    = 21;
  localparam int unsigned WORDS = MEMORY_BURST / 2;
  localparam int unsigned PW    = $clog2(MEMORY_BURST);
  localparam int unsigned WW    = $clog2(WORDS);
  localparam int unsigned CW    = $clog2(OUT_WIDTH + 1);
  localparam int unsigned RW    = $clog2(OUT_HEIGHT + 1);
  localparam int unsigned XW    = $clog2(X_STEP + 1);

  localparam logic [AW-1:0] ROW_INC   = AW'(Y_STEP * SRC_STRIDE);
  localparam logic [AW-1:0] BURST_INC = AW'(MEMORY_BURST);
`ifdef FRAME_READER_VFLIP_EN
  localparam logic [AW-1:0] FLIP_OFS  = AW'((OUT_HEIGHT - 1) * Y_STEP * SRC_STRIDE);
`endif

  localparam logic [16:0] MK_FRAME = 17'h10000;
  localparam logic [16:0] MK_LINE  = 17'h10001;
  localparam logic [16:0] MK_END   = 17'h1FFFF;

  typedef enum logic [3:0] {
    S_IDLE, S_FRAME_HDR, S_LINE_HDR, S_REQ, S_WAIT_ACK,
    S_FILL, S_DRAIN, S_NEXT_LINE, S_FRAME_END, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] row_addr_q, row_addr_d;
  logic [AW-1:0] burst_addr_q, burst_addr_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic [XW-1:0] x_ph_q, x_ph_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [WW-1:0] word_cnt_q, word_cnt_d;
  logic          abort_q, abort_d;
  logic          read_rq_q, read_rq_d;
  logic [AW-1:0] read_addr_q, read_addr_d;
  logic          mem_rd_en_q, mem_rd_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef FRAME_READER_VFLIP_EN
  logic          vflip_q, vflip_d;
`endif

  logic [31:0]   buf_q [WORDS];
  logic [31:0]   cur_word_c;
  logic [15:0]   cur_pix_c;
  logic          take_c;

  assign read_rq       = read_rq_q;
  assign read_addr     = read_addr_q;
  assign mem_rd_en     = mem_rd_en_q;
  assign busy          = busy_q;
  assign download_done = done_q;

  // Burst line buffer; word j holds source pixels 2j (low half) and 2j+1 (high half)
  always_ff @(posedge clk) begin
    if (state_q == S_FILL && rd_data_valid) begin
      buf_q[word_cnt_q] <= read_data;
    end
  end

  assign cur_word_c = buf_q[pix_cnt_q[PW-1:1]];
  assign cur_pix_c  = pix_cnt_q[0] ? cur_word_c[31:16] : cur_word_c[15:0];

  // Next-state, datapath and queue-write logic
  always_comb begin
    state_d      = state_q;
    row_addr_d   = row_addr_q;
    burst_addr_d = burst_addr_q;
    row_d        = row_q;
    out_col_d    = out_col_q;
    x_ph_d       = x_ph_q;
    pix_cnt_d    = pix_cnt_q;
    word_cnt_d   = word_cnt_q;
    abort_d      = abort_q | (abort && (state_q != S_IDLE));
    read_rq_d    = read_rq_q;
    read_addr_d  = read_addr_q;
    mem_rd_en_d  = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
`ifdef FRAME_READER_VFLIP_EN
    vflip_d      = vflip_q;
`endif
    wr_en        = 1'b0;
    queue_data_o = '0;
    take_c       = (x_ph_q == '0) && (out_col_q < CW'(OUT_WIDTH));

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef FRAME_READER_VFLIP_EN
          vflip_d    = vflip;
          row_addr_d = vflip ? base_addr + FLIP_OFS : base_addr;
`else
          row_addr_d = base_addr;
`endif
          row_d   = '0;
          busy_d  = 1'b1;
          state_d = S_FRAME_HDR;
        end
      end
      S_FRAME_HDR: begin
        if (!queue_full) begin
          wr_en        = 1'b1;
          queue_data_o = MK_FRAME;
          state_d      = S_LINE_HDR;
        end
      end
      S_LINE_HDR: begin
        if (!queue_full) begin
          wr_en        = 1'b1;
          queue_data_o = MK_LINE;
          out_col_d    = '0;
          x_ph_d       = '0;
          burst_addr_d = row_addr_q;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        read_rq_d   = 1'b1;
        read_addr_d = burst_addr_q;
        state_d     = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (read_ack) begin
          mem_rd_en_d = 1'b1;
          word_cnt_d  = '0;
          state_d     = S_FILL;
        end
      end
      S_FILL: begin
        if (rd_data_valid) begin
          word_cnt_d = word_cnt_q + WW'(1);
          if (word_cnt_q == WW'(WORDS - 1)) begin
            read_rq_d = 1'b0;
            pix_cnt_d = '0;
            state_d   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Only a pixel that is actually written can be stalled by the queue
        if (!(take_c && queue_full)) begin
          if (take_c) begin
            wr_en        = 1'b1;
            queue_data_o = {1'b0, cur_pix_c};
            out_col_d    = out_col_q + CW'(1);
          end
          x_ph_d    = (x_ph_q == XW'(X_STEP - 1)) ? '0 : x_ph_q + XW'(1);
          pix_cnt_d = pix_cnt_q + PW'(1);
          if (pix_cnt_q == PW'(MEMORY_BURST - 1)) begin
            pix_cnt_d = '0;
            if (out_col_d < CW'(OUT_WIDTH)) begin
              burst_addr_d = burst_addr_q + BURST_INC;
              state_d      = S_REQ;
            end else begin
              state_d = S_NEXT_LINE;
            end
          end
        end
      end
      S_NEXT_LINE: begin
        row_d = row_q + RW'(1);
`ifdef FRAME_READER_VFLIP_EN
        row_addr_d = vflip_q ? row_addr_q - ROW_INC : row_addr_q + ROW_INC;
`else
        row_addr_d = row_addr_q + ROW_INC;
`endif
        state_d = (row_d == RW'(OUT_HEIGHT)) ? S_FRAME_END : S_LINE_HDR;
      end
      S_FRAME_END: begin
        if (!queue_full) begin
          wr_en        = 1'b1;
          queue_data_o = MK_END;
          done_d       = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A pending abort takes effect on entry to a line/burst boundary, after any burst in flight
    if (abort_d && (state_d != state_q) &&
        (state_d inside {S_LINE_HDR, S_REQ, S_DRAIN, S_NEXT_LINE})) begin
      state_d = S_FRAME_END;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      row_addr_q   <= '0;
      burst_addr_q <= '0;
      row_q        <= '0;
      out_col_q    <= '0;
      x_ph_q       <= '0;
      pix_cnt_q    <= '0;
      word_cnt_q   <= '0;
      abort_q      <= 1'b0;
      read_rq_q    <= 1'b0;
      read_addr_q  <= '0;
      mem_rd_en_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef FRAME_READER_VFLIP_EN
      vflip_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      row_addr_q   <= row_addr_d;
      burst_addr_q <= burst_addr_d;
      row_q        <= row_d;
      out_col_q    <= out_col_d;
      x_ph_q       <= x_ph_d;
      pix_cnt_q    <= pix_cnt_d;
      word_cnt_q   <= word_cnt_d;
      abort_q      <= abort_d;
      read_rq_q    <= read_rq_d;
      read_addr_q  <= read_addr_d;
      mem_rd_en_q  <= mem_rd_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef FRAME_READER_VFLIP_EN
      vflip_q      <= vflip_d;
`endif
    end
  end

endmodule

// File: tb/tb_frame_stream_reader.sv
// Scoreboard bench for frame_stream_reader: random PSRAM timing and queue backpressure,
// expected queue entries and burst addresses derived from the frame geometry.
module tb_frame_stream_reader;

  localparam int MB    = 8;
  localparam int W     = 6;
  localparam int H     = 3;
  localparam int S     = 32;
  localparam int XS    = 2;
  localparam int YS    = 2;
  localparam int WORDS = MB / 2;
  localparam int NB    = ((W - 1) * XS) / MB + 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [20:0] base_addr;
  logic        queue_full;
  logic [16:0] queue_data_o;
  logic        wr_en;
  logic        read_rq;
  logic        read_ack;
  logic [20:0] read_addr;
  logic        mem_rd_en;
  logic [31:0] read_data;
  logic        rd_data_valid;
  logic        busy;
  logic        download_done;
`ifdef FRAME_READER_VFLIP_EN
  logic        vflip = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [16:0] exp_q[$];
  logic [20:0] exp_addr[$];

  bit bp_en = 1'b0;
  bit force_full = 1'b0;
  int rsp_st = 0, rsp_w = 0, ack_dly = 0, rsp_burst = 0, abort_burst = -1;
  bit abort_done = 1'b0;
  logic [20:0] rsp_addr;

  frame_stream_reader #(
    .MEMORY_BURST(MB), .OUT_WIDTH(W), .OUT_HEIGHT(H),
    .SRC_STRIDE(S), .X_STEP(XS), .Y_STEP(YS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr),
`ifdef FRAME_READER_VFLIP_EN
    .vflip(vflip),
`endif
    .queue_full(queue_full), .queue_data_o(queue_data_o), .wr_en(wr_en),
    .read_rq(read_rq), .read_ack(read_ack), .read_addr(read_addr),
    .mem_rd_en(mem_rd_en), .read_data(read_data), .rd_data_valid(rd_data_valid),
    .busy(busy), .download_done(download_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stored frame content: an arbitrary pixel value per 21-bit address
  function automatic logic [15:0] pix(input logic [20:0] a);
    logic [20:0] t;
    t = (a * 21'd1103) ^ 21'h15a3c;
    return t[15:0] ^ {11'd0, t[20:16]};
  endfunction

  function automatic logic [20:0] row_base(input logic [20:0] base, input bit flip, input int r);
    int rr;
    rr = flip ? (H - 1 - r) : r;
    return base + 21'(rr * YS * S);
  endfunction

  // Expected queue stream and burst addresses of one frame; abort_row<0 means a full frame
  task automatic push_frame(input logic [20:0] base, input bit flip, input int abort_row);
    logic [20:0] ra;
    exp_q.push_back(17'h10000);
    for (int r = 0; r < H; r++) begin
      ra = row_base(base, flip, r);
      exp_q.push_back(17'h10001);
      if (r == abort_row) begin
        exp_addr.push_back(ra);
        break;
      end
      for (int b = 0; b < NB; b++) exp_addr.push_back(ra + 21'(b * MB));
      for (int c = 0; c < W; c++) exp_q.push_back({1'b0, pix(ra + 21'(c * XS))});
    end
    exp_q.push_back(17'h1FFFF);
  endtask

  // Queue monitor: pops the scoreboard on every write
  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_en) begin
        check("wr_en_with_queue_full", 32'(queue_full), 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL queue_entry: unexpected entry %0h, none expected", queue_data_o);
        end else begin
          check("queue_entry", 32'(queue_data_o), 32'(exp_q.pop_front()));
        end
      end
      if (download_done) done_cnt++;
    end
  end

  // Queue backpressure driver
  initial begin
    queue_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      queue_full = force_full || (bp_en && ($urandom_range(0, 3) == 0));
    end
  end

  // PSRAM arbiter/read-port responder; also raises abort inside a chosen burst
  initial begin
    read_ack = 1'b0;
    rd_data_valid = 1'b0;
    read_data = '0;
    abort = 1'b0;
    rsp_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      read_ack = 1'b0;
      rd_data_valid = 1'b0;
      abort = 1'b0;
      if (!reset_n) begin
        rsp_st = 0;
      end else begin
        case (rsp_st)
          0: if (read_rq) begin
               ack_dly = $urandom_range(0, 3);
               rsp_st = 1;
             end
          1: if (ack_dly == 0) begin
               if (exp_addr.size() == 0) begin
                 tests++;
                 fails++;
                 $display("FAIL burst_addr: unexpected burst at %0h", read_addr);
               end else begin
                 check("burst_addr", 32'(read_addr), 32'(exp_addr.pop_front()));
               end
               rsp_addr = read_addr;
               read_ack = 1'b1;
               rsp_burst++;
               rsp_st = 2;
             end else begin
               ack_dly--;
             end
          2: begin
               check("mem_rd_en_after_ack", 32'(mem_rd_en), 32'd1);
               rsp_w = 0;
               rsp_st = 3;
             end
          3: begin
               if ((rsp_burst - 1) == abort_burst && rsp_w == 2 && !abort_done) begin
                 abort = 1'b1;
                 abort_done = 1'b1;
               end
               if ($urandom_range(0, 2) != 0) begin
                 check("read_rq_held_in_burst", 32'(read_rq), 32'd1);
                 rd_data_valid = 1'b1;
                 read_data = {pix(rsp_addr + 21'(2 * rsp_w + 1)), pix(rsp_addr + 21'(2 * rsp_w))};
                 rsp_w++;
                 if (rsp_w == WORDS) rsp_st = 4;
               end
             end
          default: begin
               check("read_rq_released", 32'(read_rq), 32'd0);
               rsp_st = 0;
             end
        endcase
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_queue_data", 32'(queue_data_o), 32'd0);
    check("rst_read_rq", 32'(read_rq), 32'd0);
    check("rst_read_addr", 32'(read_addr), 32'd0);
    check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_download_done", 32'(download_done), 32'd0);
  endtask

  // mode: 0 full frame, 1 abort inside first burst of abort_row, 2 async reset mid-burst
  task automatic run_frame(input logic [20:0] base, input bit flip, input int mode,
                           input int abort_row, input bit lat_chk, input bit hold, input bit ign);
    int d0;
    bit got;
    push_frame(base, flip, (mode == 1) ? abort_row : -1);
    rsp_burst = 0;
    abort_burst = (mode == 1) ? abort_row * NB : -1;
    abort_done = 1'b0;
    d0 = done_cnt;
    @(posedge clk);
    #2;
    base_addr = base;
`ifdef FRAME_READER_VFLIP_EN
    vflip = flip;
`endif
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    if (lat_chk) begin
      @(negedge clk);
      check("start_to_wr_en", 32'(wr_en), 32'd1);
      check("frame_start_marker", 32'(queue_data_o), 32'h10000);
    end
    if (hold) begin
      got = 1'b0;
      for (int i = 0; i < 500 && !got; i++) begin
        @(negedge clk);
        if (wr_en && !queue_data_o[16]) got = 1'b1;
      end
      check("hold_point_reached", 32'(got), 32'd1);
      force_full = 1'b1;
      repeat (5) begin
        @(negedge clk);
        check("no_write_while_full", 32'(wr_en), 32'd0);
      end
      force_full = 1'b0;
    end
    if (mode == 2) begin
      got = 1'b0;
      for (int i = 0; i < 500 && !got; i++) begin
        @(posedge clk);
        #2;
        if (rsp_st == 3 && rsp_w >= 1) got = 1'b1;
      end
      check("reset_point_reached", 32'(got), 32'd1);
      #3;
      reset_n = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      exp_addr.delete();
      repeat (2) @(posedge clk);
      #3;
      reset_n = 1'b1;
      return;
    end
    for (int i = 0; i < 5000 && done_cnt == d0; i++) begin
      @(posedge clk);
      #2;
      start = (ign && i == 30);
      if (ign && i == 30) base_addr = ~base;
    end
    start = 1'b0;
    check("done_seen", 32'(done_cnt != d0), 32'd1);
    check("busy_low_after_done", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    check("single_done_pulse", 32'(done_cnt - d0), 32'd1);
    check("queue_stream_complete", 32'(exp_q.size()), 32'd0);
    check("bursts_complete", 32'(exp_addr.size()), 32'd0);
    exp_q.delete();
    exp_addr.delete();
  endtask

  initial begin
    reset_n = 1'b1;
    start = 1'b0;
    base_addr = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;

    run_frame(21'h100, 1'b0, 0, -1, 1'b1, 1'b0, 1'b0);
    run_frame(21'($urandom), 1'b0, 0, -1, 1'b0, 1'b1, 1'b0);
    bp_en = 1'b1;
    run_frame(21'($urandom), 1'b0, 0, -1, 1'b0, 1'b0, 1'b1);
    repeat (2) run_frame(21'($urandom), 1'b0, 0, -1, 1'b0, 1'b0, 1'b0);
    run_frame(21'($urandom), 1'b0, 1, 1, 1'b0, 1'b0, 1'b0);
    run_frame(21'h1FFFC0, 1'b0, 0, -1, 1'b0, 1'b0, 1'b0);
    run_frame(21'($urandom), 1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
    run_frame(21'($urandom), 1'b0, 2, -1, 1'b0, 1'b0, 1'b0);
    run_frame(21'($urandom), 1'b0, 0, -1, 1'b0, 1'b0, 1'b0);
`ifdef FRAME_READER_VFLIP_EN
    run_frame(21'h100, 1'b1, 0, -1, 1'b0, 1'b0, 1'b0);
    run_frame(21'($urandom), 1'b1, 0, -1, 1'b0, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
